// File: rtl/kern_seq_pkg.sv
// Shared types and defaults for the scalar-kernel call sequencers.
// Holds the FSM state enum, default widths and the reset/timeout cycle constants.
package kern_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } seq_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RST_CYC     = 2;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // The timer is loaded with (cycles - 1), so clog2 of the larger budget is enough.
  function automatic int timer_width(input int rst_cyc, input int timeout_cyc);
    int max_cyc;
    max_cyc = (rst_cyc > timeout_cyc) ? rst_cyc : timeout_cyc;
    return (max_cyc > 2) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/kern_seq_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the reset-hold
// (PRE) and run-timeout (RUN) phases of the call sequencer.
module kern_seq_timer #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: cnt_d takes a default before any branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/kernel_call_seq.sv
// Upstream sequencer for HLS scalar kernels: accepts an argument, pulses the kernel
// out of reset, waits for done (or times out) and presents the result on valid/ready.
module kernel_call_seq
  import kern_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              arg_valid,
  output logic              arg_ready,
  input  logic [DATA_W-1:0] arg_data,
  output logic [DATA_W-1:0] kern_arg,
  output logic              kern_rst_n,
  input  logic              kern_done,
  input  logic [DATA_W-1:0] kern_ret,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic [CNT_W-1:0]  call_cnt,
  output logic              busy
);

  localparam int              TMR_W    = timer_width(RST_CYC, TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] RUN_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  seq_state_e        state_q;
  logic [DATA_W-1:0] kern_arg_q;
  logic [DATA_W-1:0] res_data_q;
  logic              kern_rst_n_q;
  logic              res_timeout_q;
  logic [CNT_W-1:0]  call_cnt_q;

  logic              accept;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_tc;
  logic [TMR_W-1:0]  tmr_load_val;

  assign accept = (state_q == IDLE) && arg_valid;

  // One timer serves both phases: loaded on accept for PRE, reloaded on PRE exit for RUN.
  assign tmr_load     = accept || ((state_q == PRE) && tmr_tc);
  assign tmr_load_val = accept ? PRE_LOAD : RUN_LOAD;
  assign tmr_en       = (state_q == PRE) || (state_q == RUN);

  kern_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  // kern_rst_n is registered from RUN, so it rises one cycle into RUN and drops
  // on the same edge that leaves RUN.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      kern_arg_q    <= '0;
      kern_rst_n_q  <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      call_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          kern_rst_n_q <= 1'b0;
          if (accept) begin
            kern_arg_q <= arg_data;
            state_q    <= PRE;
          end
        end
        PRE: begin
          kern_rst_n_q <= 1'b0;
          if (tmr_tc) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (kern_done) begin
            res_data_q    <= kern_ret;
            res_timeout_q <= 1'b0;
            kern_rst_n_q  <= 1'b0;
            state_q       <= OUT;
          end else if (tmr_tc) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            kern_rst_n_q  <= 1'b0;
            state_q       <= OUT;
          end else begin
            kern_rst_n_q <= 1'b1;
          end
        end
        OUT: begin
          kern_rst_n_q <= 1'b0;
          if (res_ready) begin
            call_cnt_q <= call_cnt_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          kern_rst_n_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign arg_ready   = (state_q == IDLE);
  assign res_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign kern_arg    = kern_arg_q;
  assign kern_rst_n  = kern_rst_n_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign call_cnt    = call_cnt_q;

endmodule

// File: tb/tb_kernel_call_seq.sv
// Bench for kernel_call_seq: a Sum-kernel model, an edge-counting reference model
// compared every cycle, directed boundary scenarios and a randomized phase.
module tb_kernel_call_seq;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int R  = 2;
  localparam int T  = 64;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          arg_valid;
  logic          arg_ready;
  logic [DW-1:0] arg_data;
  logic [DW-1:0] kern_arg;
  logic          kern_rst_n;
  logic          kern_done = 1'b0;
  logic [DW-1:0] kern_ret  = '0;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_timeout;
  logic [CW-1:0] call_cnt;
  logic          busy;

  always #5 sys_clk = ~sys_clk;

  kernel_call_seq #(
    .DATA_W      (DW),
    .RST_CYC     (R),
    .TIMEOUT_CYC (T),
    .CNT_W       (CW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .arg_valid   (arg_valid),
    .arg_ready   (arg_ready),
    .arg_data    (arg_data),
    .kern_arg    (kern_arg),
    .kern_rst_n  (kern_rst_n),
    .kern_done   (kern_done),
    .kern_ret    (kern_ret),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .call_cnt    (call_cnt),
    .busy        (busy)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sum kernel: done rises n+2 cycles after its reset is released, with 1+..+n.
  logic        hang;
  int unsigned k_cnt = 0;

  function automatic logic [DW-1:0] tri_sum(input logic [DW-1:0] n);
    return (n * (n + 1)) / 2;
  endfunction

  always @(posedge sys_clk) begin
    if (kern_rst_n !== 1'b1) begin
      k_cnt     <= 0;
      kern_done <= 1'b0;
      kern_ret  <= '0;
    end else begin
      k_cnt <= k_cnt + 1;
      if (!hang && (k_cnt + 1 >= kern_arg + 2)) begin
        kern_done <= 1'b1;
        kern_ret  <= tri_sum(kern_arg);
      end
    end
  end

  // Reference model: edges counted from the accepting edge (t=0). Edges R+1..R+T
  // are the run window; kern_rst_n is high from edge R+1 until the call ends.
  bit            m_ok = 1'b0;
  logic          m_act, m_out, m_to;
  int unsigned   m_t;
  logic [DW-1:0] m_arg, m_res;
  logic [CW-1:0] m_cnt;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_ok  <= 1'b1;
      m_act <= 1'b0;
      m_out <= 1'b0;
      m_to  <= 1'b0;
      m_t   <= 0;
      m_arg <= '0;
      m_res <= '0;
      m_cnt <= '0;
    end else if (m_out) begin
      if (res_ready) begin
        m_out <= 1'b0;
        m_cnt <= m_cnt + 1'b1;
      end
    end else if (m_act) begin
      m_t <= m_t + 1;
      if (m_t + 1 > R) begin
        if (kern_done) begin
          m_act <= 1'b0;
          m_out <= 1'b1;
          m_res <= kern_ret;
          m_to  <= 1'b0;
        end else if (m_t + 1 == R + T) begin
          m_act <= 1'b0;
          m_out <= 1'b1;
          m_res <= '0;
          m_to  <= 1'b1;
        end
      end
    end else if (arg_valid) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_arg <= arg_data;
    end
  end

  always @(negedge sys_clk) begin
    if (m_ok) begin
      check("cyc_arg_ready",   arg_ready,   !m_act && !m_out);
      check("cyc_busy",        busy,        m_act || m_out);
      check("cyc_res_valid",   res_valid,   m_out);
      check("cyc_kern_rst_n",  kern_rst_n,  m_act && (m_t >= R + 1));
      check("cyc_kern_arg",    kern_arg,    m_arg);
      check("cyc_res_data",    res_data,    m_res);
      check("cyc_res_timeout", res_timeout, m_to);
      check("cyc_call_cnt",    call_cnt,    m_cnt);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Bounded wait for kern_rst_n (which=0) or res_valid (which=1).
  task automatic wait_high(input string name, input bit which, input int budget);
    int n;
    n = 0;
    while (((which ? res_valid : kern_rst_n) !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
    if ((which ? res_valid : kern_rst_n) !== 1'b1) check({name, "_bound"}, 0, 1);
  endtask

  // Offers one argument from IDLE; returns the cycle stamp of the accepting edge.
  task automatic send(input logic [DW-1:0] a, input bit keep_valid, output int unsigned acc);
    arg_valid = 1'b1;
    arg_data  = a;
    tick();
    acc = cyc;
    if (!keep_valid) arg_valid = 1'b0;
  endtask

  int unsigned acc;

  initial begin
    sys_rst   = 1'b1;
    arg_valid = 1'b0;
    arg_data  = '0;
    res_ready = 1'b0;
    hang      = 1'b0;
    repeat (3) tick();
    check("rst_arg_ready",  arg_ready,  1);
    check("rst_kern_rst_n", kern_rst_n, 0);
    check("rst_res_valid",  res_valid,  0);
    check("rst_res_data",   res_data,   0);
    check("rst_call_cnt",   call_cnt,   0);
    check("rst_busy",       busy,       0);
    check("rst_kern_arg",   kern_arg,   0);
    sys_rst = 1'b0;
    tick();

    // Single call: 10 -> 55.
    send(10, 1'b0, acc);
    wait_high("single_rise", 1'b0, 20);
    check("single_rise_lat", cyc - acc, 3);
    wait_high("single_res", 1'b1, 100);
    check("single_res_lat", cyc - acc, 16);
    check("single_res_data", res_data, 55);
    check("single_res_to", res_timeout, 0);
    res_ready = 1'b1;
    tick();
    check("single_cnt", call_cnt, 1);
    check("single_busy", busy, 0);
    check("single_kern_arg_kept", kern_arg, 10);

    // Back-to-back with arg_valid held: 3 then 4.
    send(3, 1'b1, acc);
    arg_data = 4;
    wait_high("b2b_res1", 1'b1, 100);
    check("b2b_res1_data", res_data, 6);
    tick();
    check("b2b_idle_after_hs", arg_ready, 1);
    tick();
    arg_valid = 1'b0;
    check("b2b_second_accept", busy, 1);
    check("b2b_second_arg", kern_arg, 4);
    wait_high("b2b_res2", 1'b1, 100);
    check("b2b_res2_data", res_data, 10);
    tick();
    check("b2b_cnt", call_cnt, 3);

    // Backpressure: result 15 held for 20 cycles.
    res_ready = 1'b0;
    send(5, 1'b0, acc);
    wait_high("bp_res", 1'b1, 100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 15);
      check("bp_arg_ready", arg_ready, 0);
      check("bp_kern_rst_n", kern_rst_n, 0);
    end
    res_ready = 1'b1;
    tick();
    check("bp_release_idle", arg_ready, 1);
    check("bp_cnt", call_cnt, 4);

    // Timeout: kernel never finishes, result after exactly T run cycles.
    res_ready = 1'b0;
    hang = 1'b1;
    send(5, 1'b0, acc);
    wait_high("to_res", 1'b1, 200);
    check("to_lat", cyc - acc, R + T);
    check("to_flag", res_timeout, 1);
    check("to_data", res_data, 0);
    res_ready = 1'b1;
    tick();
    check("to_cnt", call_cnt, 5);
    hang = 1'b0;

    // Done on the timeout edge (n = T-4) wins; one more is a timeout.
    send(60, 1'b0, acc);
    wait_high("coin_res", 1'b1, 200);
    check("coin_lat", cyc - acc, R + T);
    check("coin_data", res_data, 1830);
    check("coin_flag", res_timeout, 0);
    tick();
    send(61, 1'b0, acc);
    wait_high("late_res", 1'b1, 200);
    check("late_lat", cyc - acc, R + T);
    check("late_data", res_data, 0);
    check("late_flag", res_timeout, 1);
    tick();
    check("late_cnt", call_cnt, 7);

    // Reset in the middle of RUN.
    send(10, 1'b0, acc);
    wait_high("mid_rise", 1'b0, 20);
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();
    check("mid_kern_rst_n", kern_rst_n, 0);
    check("mid_res_valid", res_valid, 0);
    check("mid_cnt", call_cnt, 0);
    check("mid_arg_ready", arg_ready, 1);
    sys_rst = 1'b0;
    tick();
    send(4, 1'b0, acc);
    wait_high("mid_res", 1'b1, 100);
    check("mid_next_data", res_data, 10);
    tick();
    check("mid_next_cnt", call_cnt, 1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if (arg_ready) hang = ($urandom_range(0, 7) == 0);
      arg_valid = ($urandom_range(0, 3) != 0);
      arg_data  = $urandom_range(0, 70);
      res_ready = ($urandom_range(0, 2) != 0);
      sys_rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    sys_rst   = 1'b0;
    arg_valid = 1'b0;
    res_ready = 1'b1;
    repeat (150) tick();
    check("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
